// File: rtl/ysyx_23060124_csr_ctrl_pkg.sv
// Shared encodings for the CSR sequencer: instruction ops, FSM states and
// the machine-mode CSR addresses the core implements.
package ysyx_23060124_csr_ctrl_pkg;

  typedef enum logic [2:0] {
    CSR_OP_NONE  = 3'd0,
    CSR_OP_RW    = 3'd1,
    CSR_OP_RS    = 3'd2,
    CSR_OP_RC    = 3'd3,
    CSR_OP_ECALL = 3'd4,
    CSR_OP_MRET  = 3'd5
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_TRAP,
    ST_RET,
    ST_RESP
  } csr_state_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  function automatic logic is_accepted_op(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd5);
  endfunction

  function automatic logic is_csr_op(input csr_op_e op);
    return (op == CSR_OP_RW) || (op == CSR_OP_RS) || (op == CSR_OP_RC);
  endfunction

endpackage

// File: rtl/ysyx_23060124_csr_ctrl_if.sv
// Request, CSR-file and response signals of the CSR sequencer.
// master = EXU/CSR-file/WBU environment, slave = the controller.
interface ysyx_23060124_csr_ctrl_if #(parameter int XLEN = 32);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_pc;
  logic [11:0]     i_csr_addr;
  logic [XLEN-1:0] i_rs1_data;
  logic            i_rs1_is_x0;
  logic [11:0]     o_csr_raddr;
  logic [XLEN-1:0] i_csr_rdata;
  logic            o_csr_wen;
  logic [11:0]     o_csr_waddr;
  logic [XLEN-1:0] o_csr_wdata;
  logic            o_ecall;
  logic            o_mret;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] i_mepc;
  logic [XLEN-1:0] i_mtvec;
  logic            o_valid;
  logic            i_ready;
  logic            o_rd_wen;
  logic [XLEN-1:0] o_rd_data;
  logic            o_redirect;
  logic [XLEN-1:0] o_redirect_pc;

  modport slave (
    input  i_valid, i_op, i_pc, i_csr_addr, i_rs1_data, i_rs1_is_x0,
           i_csr_rdata, i_mepc, i_mtvec, i_ready,
    output o_ready, o_csr_raddr, o_csr_wen, o_csr_waddr, o_csr_wdata,
           o_ecall, o_mret, o_pc, o_valid, o_rd_wen, o_rd_data,
           o_redirect, o_redirect_pc
  );

  modport master (
    output i_valid, i_op, i_pc, i_csr_addr, i_rs1_data, i_rs1_is_x0,
           i_csr_rdata, i_mepc, i_mtvec, i_ready,
    input  o_ready, o_csr_raddr, o_csr_wen, o_csr_waddr, o_csr_wdata,
           o_ecall, o_mret, o_pc, o_valid, o_rd_wen, o_rd_data,
           o_redirect, o_redirect_pc
  );
endinterface

// File: rtl/ysyx_23060124_csr_alu.sv
// New CSR value for CSRRW/CSRRS/CSRRC and the write-suppress decision.
module ysyx_23060124_csr_alu
  import ysyx_23060124_csr_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit RO_PROTECT = 1'b1
) (
  input  csr_op_e         op,
  input  logic [11:0]     addr,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] rs1,
  input  logic            rs1_is_x0,
  output logic [XLEN-1:0] new_val,
  output logic            suppress
);

  always_comb begin
    new_val = rs1;
    case (op)
      CSR_OP_RS: new_val = old_val | rs1;
      CSR_OP_RC: new_val = old_val & ~rs1;
      default:   new_val = rs1;
    endcase
    // Set/clear with x0 must not write; addr[11:10]==11 is the read-only space.
    suppress = (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && rs1_is_x0)
             || (RO_PROTECT && (addr[11:10] == 2'b11));
  end

endmodule

// File: rtl/ysyx_23060124_csr_ctrl.sv
// Sequences one CSR-class instruction at a time against the CSR file and
// returns either the old CSR value or a trap/return redirect target.
module ysyx_23060124_csr_ctrl
  import ysyx_23060124_csr_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit RO_PROTECT = 1'b1
) (
  input logic                      clock,
  input logic                      reset,
  ysyx_23060124_csr_ctrl_if.slave  bus
);

  csr_state_e      state, state_nxt;
  csr_op_e         op_q;
  logic [XLEN-1:0] pc_q, rs1_q, old_q, new_q, target_q;
  logic [11:0]     addr_q;
  logic            x0_q;
  logic [XLEN-1:0] alu_new;
  logic            alu_suppress;
  logic            accept;

  ysyx_23060124_csr_alu #(
    .XLEN       (XLEN),
    .RO_PROTECT (RO_PROTECT)
  ) u_alu (
    .op        (op_q),
    .addr      (addr_q),
    .old_val   (bus.i_csr_rdata),
    .rs1       (rs1_q),
    .rs1_is_x0 (x0_q),
    .new_val   (alu_new),
    .suppress  (alu_suppress)
  );

  assign accept = bus.i_valid && (state == ST_IDLE) && is_accepted_op(bus.i_op);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= CSR_OP_NONE;
      pc_q     <= '0;
      rs1_q    <= '0;
      old_q    <= '0;
      new_q    <= '0;
      target_q <= '0;
      addr_q   <= '0;
      x0_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= csr_op_e'(bus.i_op);
        pc_q   <= bus.i_pc;
        addr_q <= bus.i_csr_addr;
        rs1_q  <= bus.i_rs1_data;
        x0_q   <= bus.i_rs1_is_x0;
      end
      if (state == ST_READ) begin
        old_q <= bus.i_csr_rdata;
        new_q <= alu_new;
      end
      if (state == ST_TRAP) target_q <= bus.i_mtvec;
      if (state == ST_RET)  target_q <= bus.i_mepc;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (csr_op_e'(bus.i_op))
            CSR_OP_ECALL: state_nxt = ST_TRAP;
            CSR_OP_MRET:  state_nxt = ST_RET;
            default:      state_nxt = ST_READ;
          endcase
        end
      end
      ST_READ:  state_nxt = alu_suppress ? ST_RESP : ST_WRITE;
      ST_WRITE: state_nxt = ST_RESP;
      ST_TRAP:  state_nxt = ST_RESP;
      ST_RET:   state_nxt = ST_RESP;
      ST_RESP:  if (bus.i_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from state and gated by reset so strobes drop in the reset cycle.
  always_comb begin
    bus.o_ready       = (state == ST_IDLE);
    bus.o_csr_raddr   = '0;
    bus.o_csr_wen     = 1'b0;
    bus.o_csr_waddr   = '0;
    bus.o_csr_wdata   = '0;
    bus.o_ecall       = 1'b0;
    bus.o_mret        = 1'b0;
    bus.o_pc          = '0;
    bus.o_valid       = 1'b0;
    bus.o_rd_wen      = 1'b0;
    bus.o_rd_data     = '0;
    bus.o_redirect    = 1'b0;
    bus.o_redirect_pc = '0;
    if (!reset) begin
      case (state)
        ST_READ:  bus.o_csr_raddr = addr_q;
        ST_WRITE: begin
          bus.o_csr_wen   = 1'b1;
          bus.o_csr_waddr = addr_q;
          bus.o_csr_wdata = new_q;
        end
        ST_TRAP: begin
          bus.o_ecall = 1'b1;
          bus.o_pc    = pc_q;
        end
        ST_RET:  bus.o_mret = 1'b1;
        ST_RESP: begin
          bus.o_valid = 1'b1;
          if (is_csr_op(op_q)) begin
            bus.o_rd_wen  = 1'b1;
            bus.o_rd_data = old_q;
          end else begin
            bus.o_redirect    = 1'b1;
            bus.o_redirect_pc = target_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060124_csr_ctrl.sv
// Self-checking bench for the CSR sequencer: directed table, random
// transactions against a behavioural model, and reset/ignore corner cases.
module tb_ysyx_23060124_csr_ctrl;
  import ysyx_23060124_csr_ctrl_pkg::*;

  localparam int XLEN = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ysyx_23060124_csr_ctrl_if #(.XLEN(XLEN)) bus ();

  ysyx_23060124_csr_ctrl #(
    .XLEN       (XLEN),
    .RO_PROTECT (1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // CSR file stand-in: data only valid for the right address / strobe.
  logic [11:0] cur_addr;
  logic [31:0] cur_old, cur_mtvec, cur_mepc;
  assign bus.i_csr_rdata = (bus.o_csr_raddr == cur_addr) ? cur_old : 32'hBAD0_BAD0;
  assign bus.i_mtvec     = bus.o_ecall ? cur_mtvec : 32'h0BAD_C0DE;
  assign bus.i_mepc      = bus.o_mret  ? cur_mepc  : 32'h0BAD_C0DE;

  typedef struct {
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] rs1;
    logic        x0;
    logic [31:0] pc;
    logic [31:0] old;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    int unsigned stall;
    int unsigned lat;
    logic        wen;
    logic [31:0] wdata;
    logic        rd_wen;
    logic [31:0] rd_data;
    logic        redirect;
    logic [31:0] rpc;
  } vec_t;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: derives the expected response straight from the op rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic read_only = (v.addr[11:10] == 2'b11);
    r.wen = 0; r.wdata = 0; r.rd_wen = 0; r.rd_data = 0; r.redirect = 0; r.rpc = 0;
    case (v.op)
      3'd1, 3'd2, 3'd3: begin
        if (v.op == 3'd1)      r.wdata = v.rs1;
        else if (v.op == 3'd2) r.wdata = v.old | v.rs1;
        else                   r.wdata = v.old & ~v.rs1;
        r.wen     = !read_only && !((v.op != 3'd1) && v.x0);
        r.lat     = r.wen ? 3 : 2;
        r.rd_wen  = 1;
        r.rd_data = v.old;
      end
      3'd4: begin r.lat = 2; r.redirect = 1; r.rpc = v.mtvec; end
      default: begin r.lat = 2; r.redirect = 1; r.rpc = v.mepc; end
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic run(input vec_t v);
    int unsigned wen_n = 0, ecall_n = 0, mret_n = 0, k = 1, lat = 0;
    logic [31:0] waddr_seen = 0, wdata_seen = 0, pc_seen = 0;
    logic got = 0;
    cur_addr = v.addr; cur_old = v.old; cur_mtvec = v.mtvec; cur_mepc = v.mepc;
    chk("ready_idle", bus.o_ready, 1);
    bus.i_valid = 1; bus.i_op = v.op; bus.i_pc = v.pc; bus.i_csr_addr = v.addr;
    bus.i_rs1_data = v.rs1; bus.i_rs1_is_x0 = v.x0; bus.i_ready = 0;
    tick();
    // Scramble request fields so the DUT must use its captured copy.
    bus.i_valid = 0; bus.i_op = 3'd0; bus.i_pc = $urandom; bus.i_csr_addr = 12'($urandom);
    bus.i_rs1_data = $urandom; bus.i_rs1_is_x0 = ~v.x0;
    while (!got && k <= 8) begin
      if (bus.o_valid) begin
        got = 1; lat = k;
      end else begin
        chk("strobe_onehot", 32'(($countones({bus.o_csr_wen, bus.o_ecall, bus.o_mret}) <= 1)), 1);
        chk("ready_busy", bus.o_ready, 0);
        if (bus.o_csr_wen) begin wen_n++; waddr_seen = 32'(bus.o_csr_waddr); wdata_seen = bus.o_csr_wdata; end
        if (bus.o_ecall) begin ecall_n++; pc_seen = bus.o_pc; end
        if (bus.o_mret) mret_n++;
        tick(); k++;
      end
    end
    chk("latency", lat, v.lat);
    chk("wen_pulses", wen_n, 32'(v.wen));
    if (v.wen) begin
      chk("waddr", waddr_seen, 32'(v.addr));
      chk("wdata", wdata_seen, v.wdata);
    end
    chk("ecall_pulses", ecall_n, 32'(v.op == 3'd4));
    if (v.op == 3'd4) chk("ecall_pc", pc_seen, v.pc);
    chk("mret_pulses", mret_n, 32'(v.op == 3'd5));
    for (int unsigned s = 0; s <= v.stall; s++) begin
      chk("valid", bus.o_valid, 1);
      chk("rd_wen", bus.o_rd_wen, v.rd_wen);
      chk("redirect", bus.o_redirect, v.redirect);
      if (v.rd_wen)   chk("rd_data", bus.o_rd_data, v.rd_data);
      if (v.redirect) chk("redirect_pc", bus.o_redirect_pc, v.rpc);
      chk("resp_strobes", {bus.o_csr_wen, bus.o_ecall, bus.o_mret}, 0);
      chk("ready_resp", bus.o_ready, 0);
      if (s == v.stall) bus.i_ready = 1;
      tick();
    end
    bus.i_ready = 0;
    chk("ready_after", bus.o_ready, 1);
    chk("valid_after", bus.o_valid, 0);
  endtask

  function automatic logic [31:0] all_outputs_or();
    return bus.o_valid | bus.o_csr_wen | bus.o_ecall | bus.o_mret | bus.o_rd_wen
         | bus.o_redirect | bus.o_rd_data | bus.o_redirect_pc | 32'(bus.o_csr_waddr)
         | bus.o_csr_wdata | bus.o_pc | 32'(bus.o_csr_raddr);
  endfunction

  vec_t tbl[8];
  logic [11:0] addr_pool[7] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hF11, 12'hF12, 12'h7C0};

  initial begin
    int unsigned cnt;
    vec_t v;
    //        op    addr     rs1           x0   pc            old           mtvec         mepc          st lat wen  wdata         rdw  rd_data       redir rpc
    tbl[0] = '{3'd1, 12'h305, 32'h80000100, 1'b0, 32'h80000000, 32'h00000000, 32'h0, 32'h0, 0, 3, 1'b1, 32'h80000100, 1'b1, 32'h00000000, 1'b0, 32'h0};
    tbl[1] = '{3'd2, 12'h300, 32'h00000008, 1'b0, 32'h80000004, 32'h00001800, 32'h0, 32'h0, 0, 3, 1'b1, 32'h00001808, 1'b1, 32'h00001800, 1'b0, 32'h0};
    tbl[2] = '{3'd2, 12'h300, 32'h00000008, 1'b1, 32'h80000008, 32'h00001800, 32'h0, 32'h0, 0, 2, 1'b0, 32'h0,         1'b1, 32'h00001800, 1'b0, 32'h0};
    tbl[3] = '{3'd1, 12'hF11, 32'h12345678, 1'b0, 32'h8000000C, 32'h79737978, 32'h0, 32'h0, 0, 2, 1'b0, 32'h0,         1'b1, 32'h79737978, 1'b0, 32'h0};
    tbl[4] = '{3'd4, 12'h000, 32'h0,        1'b0, 32'h80000040, 32'h0, 32'h80000200, 32'h11110000, 0, 2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h80000200};
    tbl[5] = '{3'd5, 12'h000, 32'h0,        1'b0, 32'h80000200, 32'h0, 32'h22220000, 32'h80000040, 4, 2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h80000040};
    tbl[6] = '{3'd3, 12'h342, 32'h0F0F0F0F, 1'b0, 32'h80000010, 32'hFFFF00FF, 32'h0, 32'h0, 1, 3, 1'b1, 32'hF0F000F0, 1'b1, 32'hFFFF00FF, 1'b0, 32'h0};
    tbl[7] = '{3'd1, 12'h341, 32'h00000000, 1'b1, 32'h80000014, 32'h80000040, 32'h0, 32'h0, 2, 3, 1'b1, 32'h00000000, 1'b1, 32'h80000040, 1'b0, 32'h0};

    bus.i_valid = 0; bus.i_op = 0; bus.i_pc = 0; bus.i_csr_addr = 0; bus.i_rs1_data = 0;
    bus.i_rs1_is_x0 = 0; bus.i_ready = 0;
    cur_addr = 0; cur_old = 0; cur_mtvec = 0; cur_mepc = 0;
    reset = 1;
    tick(); tick();
    chk("rst_ready", bus.o_ready, 1);
    chk("rst_outputs", all_outputs_or(), 0);
    reset = 0;
    tick();
    chk("idle_ready", bus.o_ready, 1);
    chk("idle_outputs", all_outputs_or(), 0);

    foreach (tbl[i]) run(tbl[i]);

    // NONE and reserved ops are not accepted.
    for (int op = 0; op < 8; op++) begin
      if (op >= 1 && op <= 5) continue;
      bus.i_valid = 1; bus.i_op = 3'(op); bus.i_csr_addr = 12'h300;
      tick();
      bus.i_valid = 0; bus.i_op = 0;
      chk("ignore_ready", bus.o_ready, 1);
      tick();
      chk("ignore_quiet", all_outputs_or(), 0);
    end

    // Reset during the READ cycle of a write-bound CSRRW discards it.
    cur_addr = 12'h300; cur_old = 32'h5;
    bus.i_valid = 1; bus.i_op = 3'd1; bus.i_csr_addr = 12'h300; bus.i_rs1_data = 32'hA5A5A5A5;
    bus.i_rs1_is_x0 = 0;
    tick();
    bus.i_valid = 0; bus.i_op = 0;
    chk("read_raddr", 32'(bus.o_csr_raddr), 32'h300);
    reset = 1;
    tick();
    chk("rstread_ready", bus.o_ready, 1);
    chk("rstread_valid", bus.o_valid, 0);
    chk("rstread_wen", bus.o_csr_wen, 0);
    reset = 0;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      cnt += 32'(bus.o_csr_wen) + 32'(bus.o_valid);
    end
    chk("rstread_no_activity", cnt, 0);

    // Reset raised inside WRITE drops the strobe in the same cycle.
    bus.i_valid = 1; bus.i_op = 3'd1;
    tick();
    bus.i_valid = 0; bus.i_op = 0;
    tick();
    chk("write_wen", bus.o_csr_wen, 1);
    reset = 1;
    #1;
    chk("rstwrite_wen_drop", bus.o_csr_wen, 0);
    tick();
    reset = 0;
    chk("rstwrite_ready", bus.o_ready, 1);
    tick();

    for (int n = 0; n < 40; n++) begin
      v = tbl[0];
      v.op    = 3'($urandom_range(1, 5));
      v.addr  = addr_pool[$urandom_range(0, 6)];
      v.rs1   = $urandom;
      v.x0    = 1'($urandom_range(0, 1));
      v.pc    = $urandom;
      v.old   = $urandom;
      v.mtvec = $urandom;
      v.mepc  = $urandom;
      v.stall = $urandom_range(0, 3);
      run(model(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
